// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressable, big-endian data memory for the MEM stage. Requests
//   arrive on a valid/ready port and responses leave on a registered,
//   one-cycle pulse. Supports byte/half/word accesses with signed or
//   unsigned load extension and a configurable read latency. Misaligned,
//   illegal-size and out-of-range requests are answered with an error and
//   leave memory untouched. After every reset the array is filled with its
//   own byte index, one word per cycle, while init_busy is high.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   req_valid   request present
//   req_ready   request can be accepted this cycle (state == IDLE)
//   req_write   1 = store, 0 = load
//   req_size    00 byte, 01 half, 10 word, 11 illegal
//   req_signed  loads: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_wdata   store data, right-justified
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   load result; 0 for stores, errors and idle cycles
//   rsp_error   error flag, qualified by rsp_valid
//   init_busy   high while self-initialisation runs
module data_memory_ctrl #(
  parameter int DEPTH_BYTES  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        init_busy
);

  localparam int AW     = $clog2(DEPTH_BYTES);
  localparam int PW     = AW - 2;
  localparam int NWORDS = DEPTH_BYTES / 4;

  localparam logic [PW-1:0] PTR_LAST = PW'(NWORDS - 1);
  localparam logic [1:0]    LAT_M1   = 2'(READ_LATENCY - 1);
  localparam logic [32:0]   DEPTH_33 = 33'(DEPTH_BYTES);

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_IDLE    = 2'd1;
  localparam logic [1:0] ST_RD_WAIT = 2'd2;

  logic [7:0]    mem [DEPTH_BYTES];

  logic [1:0]    state;
  logic [PW-1:0] ptr;
  logic [1:0]    cnt;
  logic [31:0]   hold_data;

  logic          accept;
  logic [2:0]    nbytes;
  logic [32:0]   end_addr;
  logic          align_err;
  logic          range_err;
  logic          req_err;
  logic          store_ok;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;
  logic [31:0]   load_data;

  // Initial content of byte address a is the low 8 bits of a itself.
  function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
    logic [31:0] w;
    w = 32'(a);
    return w[7:0];
  endfunction

  // Request decode: byte count, alignment and range checks, acceptance.
  always_comb begin
    accept    = req_valid && req_ready;
    nbytes    = 3'd1;
    align_err = 1'b0;
    case (req_size)
      2'b00: begin
        nbytes    = 3'd1;
        align_err = 1'b0;
      end
      2'b01: begin
        nbytes    = 3'd2;
        align_err = req_addr[0];
      end
      2'b10: begin
        nbytes    = 3'd4;
        align_err = |req_addr[1:0];
      end
      default: begin
        nbytes    = 3'd1;
        align_err = 1'b1;
      end
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range.
    end_addr  = {1'b0, req_addr} + {30'd0, nbytes} - 33'd1;
    range_err = (end_addr >= DEPTH_33);
    req_err   = align_err || range_err;
    store_ok  = accept && req_write && !req_err;
  end

  // Byte lanes and load extension; indices wrap harmlessly when req_err is set.
  always_comb begin
    a0 = req_addr[AW-1:0];
    a1 = a0 + AW'(1);
    a2 = a0 + AW'(2);
    a3 = a0 + AW'(3);
    b0 = mem[a0];
    b1 = mem[a1];
    b2 = mem[a2];
    b3 = mem[a3];
    load_data = 32'd0;
    case (req_size)
      2'b00:   load_data = {{24{req_signed && b0[7]}}, b0};
      2'b01:   load_data = {{16{req_signed && b0[7]}}, b0, b1};
      2'b10:   load_data = {b0, b1, b2, b3};
      default: load_data = 32'd0;
    endcase
  end

  // Storage array: index-pattern fill during INIT, store writes on accept.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      for (int k = 0; k < 4; k++) begin
        mem[{ptr, 2'(k)}] <= init_byte({ptr, 2'(k)});
      end
    end else if (store_ok) begin
      case (req_size)
        2'b00: mem[a0] <= req_wdata[7:0];
        2'b01: begin
          mem[a0] <= req_wdata[15:8];
          mem[a1] <= req_wdata[7:0];
        end
        2'b10: begin
          mem[a0] <= req_wdata[31:24];
          mem[a1] <= req_wdata[23:16];
          mem[a2] <= req_wdata[15:8];
          mem[a3] <= req_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // Control FSM with registered ready/busy and response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_INIT;
      ptr       <= '0;
      cnt       <= 2'd0;
      hold_data <= 32'd0;
      req_ready <= 1'b0;
      init_busy <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_error <= 1'b0;
      case (state)
        ST_INIT: begin
          ptr <= ptr + PW'(1);
          if (ptr == PTR_LAST) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            if (req_write || req_err) begin
              rsp_valid <= 1'b1;
              rsp_error <= req_err;
            end else if (READ_LATENCY == 1) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= load_data;
            end else begin
              // Data is captured now; the response fires when cnt reaches 1.
              hold_data <= load_data;
              cnt       <= LAT_M1;
              state     <= ST_RD_WAIT;
              req_ready <= 1'b0;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt == 2'd1) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_rdata <= hold_data;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state     <= ST_INIT;
          ptr       <= '0;
          cnt       <= 2'd0;
          req_ready <= 1'b0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl
//   Scoreboard bench for data_memory_ctrl. Unit A (READ_LATENCY = 1) gets
//   directed size/error/back-to-back traffic followed by random traffic;
//   unit B (READ_LATENCY = 4) covers init timing, multi-cycle read timing and
//   reset during an outstanding read. Each accepted request pushes its
//   expected response (data, error, due time) computed by a byte-array
//   reference model; per-unit monitors pop and compare on rsp_valid.
`timescale 1ns/1ps
module tb_data_memory_ctrl;

  localparam int DEPTH = 256;
  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    longint      due;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  logic a_valid, a_ready, a_write, a_signed, a_rsp_valid, a_error, a_busy;
  logic [1:0] a_size;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic b_valid, b_ready, b_write, b_signed, b_rsp_valid, b_error, b_busy;
  logic [1:0] b_size;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int tests = 0;
  int fails = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic [7:0] ref_mem [2][DEPTH];

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(rst_a),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_size(a_size), .req_signed(a_signed), .req_addr(a_addr),
    .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
    .rsp_error(a_error), .init_busy(a_busy)
  );

  data_memory_ctrl #(.DEPTH_BYTES(DEPTH), .READ_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(rst_b),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_size(b_size), .req_signed(b_signed), .req_addr(b_addr),
    .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .rsp_error(b_error), .init_busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: big-endian byte array, spec error rules, plain arithmetic.
  function automatic exp_t model(input int u, input logic wr, input logic [1:0] sz,
                                 input logic sg, input logic [31:0] ad, input logic [31:0] wd);
    exp_t e;
    int nb;
    longint last;
    logic [31:0] v;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'({32'd0, ad}) + longint'(nb) - 64'sd1;
    e.err = (sz == 2'd3) || (sz == 2'd1 && ad[0]) || (sz == 2'd2 && ad[1:0] != 2'd0)
            || (last >= longint'(DEPTH));
    e.rdata = 32'd0;
    e.due = 0;
    if (!e.err) begin
      if (wr) begin
        for (int k = 0; k < nb; k++) ref_mem[u][int'(ad) + k] = wd[8*(nb-1-k) +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < nb; k++) v = (v << 8) | 32'(ref_mem[u][int'(ad) + k]);
        if (sg && nb == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sg && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
        e.rdata = v;
      end
    end
    return e;
  endfunction

  function automatic logic get_ready(input int u);
    return (u == 0) ? a_ready : b_ready;
  endfunction

  task automatic drive(input int u, input logic v, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad, input logic [31:0] wd);
    if (u == 0) begin
      a_valid = v; a_write = wr; a_size = sz; a_signed = sg; a_addr = ad; a_wdata = wd;
    end else begin
      b_valid = v; b_write = wr; b_size = sz; b_signed = sg; b_addr = ad; b_wdata = wd;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic issue(input int u, input logic wr, input logic [1:0] sz,
                       input logic sg, input logic [31:0] ad, input logic [31:0] wd);
    int n;
    exp_t e;
    n = 0;
    drive(u, 1'b1, wr, sz, sg, ad, wd);
    while (!get_ready(u) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout u%0d: req_ready stayed 0, required 1 within 100 cycles", u);
      drive(u, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    end else begin
      @(posedge clk);
      e = model(u, wr, sz, sg, ad, wd);
      e.due = longint'($time) + 5 +
              ((wr || e.err) ? 0 : 10 * (((u == 0) ? LAT_A : LAT_B) - 1));
      if (u == 0) qa.push_back(e);
      else qb.push_back(e);
      @(negedge clk);
      drive(u, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  // Reset for 3 cycles, check reset outputs, release and time the init sweep.
  task automatic do_reset(input int u);
    int n;
    if (u == 0) rst_a = 1'b1; else rst_b = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[u][i] = 8'(i);
    repeat (3) begin
      @(negedge clk);
      check("reset_rsp_valid", 32'((u == 0) ? a_rsp_valid : b_rsp_valid), 32'd0);
      check("reset_req_ready", 32'(get_ready(u)), 32'd0);
      check("reset_init_busy", 32'((u == 0) ? a_busy : b_busy), 32'd1);
    end
    if (u == 0) rst_a = 1'b0; else rst_b = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (((u == 0) ? a_busy : b_busy) && n < 1000);
    check("init_cycles", 32'(n), 32'(DEPTH / 4));
    @(negedge clk);
    check("ready_after_init", 32'(get_ready(u)), 32'd1);
  endtask

  // Monitor for unit A: pop and compare on every response pulse.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_rsp_valid === 1'b1) begin
      if (qa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL a_unexpected_rsp: rsp_valid=1 with nothing pending, required 0 at %0t", $time);
      end else begin
        e = qa.pop_front();
        check("a_rdata", a_rdata, e.rdata);
        check("a_error", 32'(a_error), 32'(e.err));
        check("a_rsp_time", 32'($time), 32'(e.due));
      end
    end else begin
      check("a_idle_rdata", a_rdata, 32'd0);
      check("a_idle_error", 32'(a_error), 32'd0);
    end
  end

  // Monitor for unit B.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_rsp_valid === 1'b1) begin
      if (qb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL b_unexpected_rsp: rsp_valid=1 with nothing pending, required 0 at %0t", $time);
      end else begin
        e = qb.pop_front();
        check("b_rdata", b_rdata, e.rdata);
        check("b_error", 32'(b_error), 32'(e.err));
        check("b_rsp_time", 32'($time), 32'(e.due));
      end
    end else begin
      check("b_idle_rdata", b_rdata, 32'd0);
      check("b_idle_error", 32'(b_error), 32'd0);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 ns, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t dropped;
    logic [31:0] ad;
    logic [1:0] sz;
    int sel;
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);

    // Unit A: init, sizes, errors, back-to-back.
    do_reset(0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF);
    issue(0, 1'b0, 2'd0, 1'b1, 32'h21, 32'd0);
    issue(0, 1'b0, 2'd0, 1'b0, 32'h21, 32'd0);
    issue(0, 1'b0, 2'd1, 1'b1, 32'h22, 32'd0);
    issue(0, 1'b0, 2'd1, 1'b0, 32'h22, 32'd0);
    issue(0, 1'b1, 2'd0, 1'b0, 32'h23, 32'h0000005A);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h20, 32'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h22, 32'd0);
    issue(0, 1'b1, 2'd1, 1'b0, 32'h05, 32'h0000A5A5);
    issue(0, 1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFFFFFF);
    issue(0, 1'b0, 2'd2, 1'b0, 32'hFE, 32'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'd0);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h04, 32'd0);
    issue(0, 1'b1, 2'd2, 1'b0, 32'h80, 32'h11223344);
    issue(0, 1'b0, 2'd2, 1'b0, 32'h80, 32'd0);
    issue(0, 1'b0, 2'd0, 1'b0, 32'hFF, 32'd0);

    // Unit A: random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 7);
      sz = (sel < 2) ? 2'd0 : (sel < 4) ? 2'd1 : (sel < 7) ? 2'd2 : 2'd3;
      sel = $urandom_range(0, 9);
      if (sel == 0) ad = $urandom;
      else if (sel == 1) ad = 32'($urandom_range(248, 263));
      else ad = 32'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'd1) ad[0] = 1'b0;
        if (sz == 2'd2) ad[1:0] = 2'b00;
      end
      issue(0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom);
    end

    // Unit B: init timing, then a multi-cycle read with ready held low.
    do_reset(1);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'd0);
    for (int k = 0; k < LAT_B - 1; k++) begin
      check("b_ready_low_in_wait", 32'(b_ready), 32'd0);
      @(negedge clk);
    end
    check("b_ready_after_wait", 32'(b_ready), 32'd1);
    issue(1, 1'b0, 2'd0, 1'b1, 32'h8F, 32'd0);
    issue(1, 1'b0, 2'd1, 1'b0, 32'h11, 32'd0);

    // Unit B: reset two cycles into an outstanding read.
    issue(1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEBABE);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    dropped = qb.pop_back();
    repeat (6) begin
      @(negedge clk);
      check("b_no_rsp_after_reset", 32'(b_rsp_valid), 32'd0);
    end
    do_reset(1);
    issue(1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);

    repeat (10) @(negedge clk);
    check("qa_drained", 32'(qa.size()), 32'd0);
    check("qb_drained", 32'(qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised byte-addressable data memory for the MEM stage, with a valid/ready request port and a registered response port.
- Supports byte, half and word accesses, signed or unsigned load extension, and a configurable read latency.
- Flags misaligned and out-of-range accesses as errors instead of corrupting memory.
- After every reset it initialises itself sequentially, one word per cycle.

Parameters:
- DEPTH_BYTES, 256, storage size in bytes; power of two, multiple of 4, range 16..4096.
- READ_LATENCY, 1, cycles from read accept to rsp_valid; range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result; 0 for stores and errors.
- rsp_error  out  1  qualified by rsp_valid.
- init_busy  out  1  high while self-initialisation runs.

Behaviour:
- States: INIT, IDLE, RD_WAIT.
- Reset asserted (async):
  - state = INIT, init pointer = 0, counter cleared.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, req_ready = 0, init_busy = 1.
  - Any in-flight read is discarded with no response.
  - Reset mid-operation behaves identically.
- INIT:
  - Each cycle writes 4 bytes, M[i] = i[7:0] for i = 4p..4p+3, then p += 1.
  - Runs for DEPTH_BYTES/4 cycles after reset deasserts, then moves to IDLE.
  - init_busy drops on the same edge.
- req_ready = (state == IDLE). A request is accepted on a rising edge where req_valid and req_ready are both high.
- Error checks at accept; an error makes no memory change:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size 11;
  - addr + bytes - 1 >= DEPTH_BYTES (all 32 address bits compared, no wrap).
- Byte ordering is big-endian: the lowest address holds the most significant byte.
  - SW: M[a] = wdata[31:24], M[a+1] = wdata[23:16], M[a+2] = wdata[15:8], M[a+3] = wdata[7:0].
  - SH: M[a] = wdata[15:8], M[a+1] = wdata[7:0].
  - SB: M[a] = wdata[7:0].
  - LW returns {M[a], M[a+1], M[a+2], M[a+3]}.
  - LH returns {M[a], M[a+1]}, extended per req_signed.
  - LB returns M[a], extended per req_signed.
  - req_signed is ignored for words.
- Stores and errored requests:
  - Memory is written on the accept edge.
  - rsp_valid = 1 on the next cycle with rdata = 0 and error set accordingly.
  - State stays IDLE, so back-to-back requests are allowed every cycle.
- Loads:
  - Data is snapshotted at the accept edge.
  - rsp_valid asserts exactly READ_LATENCY cycles after accept.
  - READ_LATENCY = 1: stay in IDLE, back-to-back loads allowed.
  - READ_LATENCY > 1: enter RD_WAIT with counter = READ_LATENCY-1 and hold req_ready low. Decrement each cycle; at 1, return to IDLE and assert rsp_valid on that edge.
- Read-after-write: a store accepted at edge n is visible to a load accepted at edge n+1 or later.
- There is no backpressure on responses; the consumer must always accept them.
- req_* inputs are ignored whenever req_ready = 0.
- rsp_rdata and rsp_error are held at 0 when rsp_valid = 0.

Test Plan:
- Init: reset high 3 cycles then low, DEPTH_BYTES = 256 → init_busy high for exactly 64 cycles, then req_ready = 1. LW @0x10 → 0x10111213.
- Sizes: SW 0xDEADBEEF @0x20; then LB signed @0x21 → 0xFFFFFFAD; LBU @0x21 → 0x000000AD; LH signed @0x22 → 0xFFFFBEEF; LHU @0x22 → 0x0000BEEF; SB 0x5A @0x23, then LW @0x20 → 0xDEADBE5A.
- Errors: LW @0x22, SH @0x05, size 11 @0x00, LW @0xFE (DEPTH 256) → each gives rsp_valid with error = 1 and rdata = 0. LW @0x04 afterwards → 0x04050607, showing memory is unchanged.
- Latency: READ_LATENCY = 3, LW accepted at edge n → req_ready low for edges n+1 and n+2, rsp_valid only at n+3. Back-to-back SW/LW at READ_LATENCY = 1 → rsp_valid on consecutive cycles, and the LW returns the new data.
- Reset mid-read: READ_LATENCY = 4, reset asserted 2 cycles after a load accept → no response ever appears, the INIT sequence re-runs, and previously stored data is overwritten by the index pattern.
